uart_trig_ctrl: RTL and testbench



---
 rtl/uart_trig_pkg.sv | 30 +++
 rtl/uart_rx.sv | 105 ++++++++++
 rtl/uart_tx.sv | 59 +++++
 rtl/uart_trig_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_trig_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_trig_pkg.sv
// -----------------------------------------------------------------------------
// uart_trig_pkg
// Shared definitions for the UART trigger/control block:
//   - command byte constants (set, trigger, pad, acknowledge)
//   - parser state enumeration
//   - bit-period helper (clocks per serial bit)
// -----------------------------------------------------------------------------
package uart_trig_pkg;

    localparam logic [7:0] CMD_SET  = 8'h53;
    localparam logic [7:0] CMD_TRIG = 8'h5C;
    localparam logic [7:0] CMD_PAD  = 8'h00;
    localparam logic [7:0] ACK      = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S_ZERO,
        ST_S_CH,
        ST_S_VAL,
        ST_T_ZERO,
        ST_ACK
    } parser_state_e;

    // Clocks per serial bit for a given system clock and baud rate.
    function automatic int unsigned bit_period(input int unsigned clk_hz,
                                               input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with a two-flop input synchronizer.
// Ports:
//   clk, nrst    : system clock, asynchronous active-low reset
//   rx_i         : raw serial input (idle high)
//   rx_sync_o    : synchronized copy of rx_i
//   valid_o      : one-clock strobe at the stop-bit centre of a good byte
//   data_o       : received byte, held until the next good byte
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned BIT_CLKS = 1250
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_i,
    output logic       rx_sync_o,
    output logic       valid_o,
    output logic [7:0] data_o
);

    localparam int unsigned HALF = BIT_CLKS / 2;
    localparam int unsigned CW   = $clog2(BIT_CLKS + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e      state_q;
    logic [1:0]     sync_q;
    logic           prev_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           valid_q;
    logic [7:0]     data_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= sync_q[1];
            valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // Only a true high-to-low transition starts a frame, so a
                    // line left low by a broken stop bit cannot retrigger.
                    if (prev_q && !sync_q[1]) begin
                        state_q <= RX_START;
                        cnt_q   <= CW'(HALF - 1);
                    end
                end
                RX_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!sync_q[1]) begin
                        state_q <= RX_DATA;
                        cnt_q   <= CW'(BIT_CLKS - 1);
                        bit_q   <= '0;
                    end else begin
                        state_q <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {sync_q[1], shift_q[7:1]};
                        cnt_q   <= CW'(BIT_CLKS - 1);
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Re-arm at the stop-bit centre so a following start
                        // edge half a bit later is still caught.
                        state_q <= RX_IDLE;
                        if (sync_q[1]) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_sync_o = sync_q[1];
    assign valid_o   = valid_q;
    assign data_o    = data_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter, LSB first.
// Ports:
//   clk, nrst : system clock, asynchronous active-low reset
//   start_i   : request to send data_i; ignored while a frame is in progress
//   data_i    : byte to send
//   tx_o      : serial output (idle high), registered
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned BIT_CLKS = 1250
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o
);

    localparam int unsigned CW = $clog2(BIT_CLKS + 1);

    logic           tx_q;
    logic           busy_q;
    logic [8:0]     shift_q;
    logic [3:0]     left_q;
    logic [CW-1:0]  cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            shift_q <= '1;
            left_q  <= '0;
            cnt_q   <= '0;
        end else if (!busy_q) begin
            if (start_i) begin
                // Start bit goes out immediately; data bits then stop bit
                // are shifted from shift_q.
                tx_q    <= 1'b0;
                shift_q <= {1'b1, data_i};
                left_q  <= 4'd9;
                cnt_q   <= CW'(BIT_CLKS - 1);
                busy_q  <= 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end else if (left_q == '0) begin
            busy_q <= 1'b0;
        end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[8:1]};
            left_q  <= left_q - 1'b1;
            cnt_q   <= CW'(BIT_CLKS - 1);
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/uart_trig_ctrl.sv
// -----------------------------------------------------------------------------
// uart_trig_ctrl
// Serial-command front end for four trigger channels with 8-bit control
// values. Commands:
//   53 00 ch val : vctr[ch] = val, arm channel ch, ack 0xA5
//   5C 00        : pulse every armed channel for TRIG_W clocks, clear arms, ack
// Ports:
//   clk, nrst                 : system clock, asynchronous active-low reset
//   rx                        : serial command input (idle high)
//   tx                        : serial acknowledge output (idle high)
//   txD                       : synchronized rx (debug loopback)
//   trigout_ch0..trigout_ch3  : trigger pulses
//   vctrout_ch0               : channel 0 control value
// -----------------------------------------------------------------------------
module uart_trig_ctrl
    import uart_trig_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned TRIG_W       = 12,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic       tx,
    output logic       txD,
    output logic       trigout_ch0,
    output logic       trigout_ch1,
    output logic       trigout_ch2,
    output logic       trigout_ch3,
    output logic [7:0] vctrout_ch0
);

    localparam int unsigned BIT_CLKS     = bit_period(CLK_HZ, BAUD);
    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;
    localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned PW           = $clog2(TRIG_W + 1);

    logic       rx_valid;
    logic [7:0] rx_data;

    parser_state_e   state_q;
    logic [7:0]      ch_q;
    logic [3:0][7:0] vctr_q;
    logic [3:0]      armed_q;
    logic [3:0]      trig_q;
    logic [PW-1:0]   pcnt_q;
    logic            ack_q;
    logic [TW-1:0]   tmo_q;

    uart_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
        .clk       (clk),
        .nrst      (nrst),
        .rx_i      (rx),
        .rx_sync_o (txD),
        .valid_o   (rx_valid),
        .data_o    (rx_data)
    );

    uart_tx #(.BIT_CLKS(BIT_CLKS)) u_tx (
        .clk     (clk),
        .nrst    (nrst),
        .start_i (ack_q),
        .data_i  (ACK),
        .tx_o    (tx)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            vctr_q  <= '0;
            armed_q <= '0;
            trig_q  <= '0;
            pcnt_q  <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            ack_q <= 1'b0;

            // Pulse timer: a running pulse is never touched by set commands.
            if (pcnt_q != '0) begin
                pcnt_q <= pcnt_q - 1'b1;
            end else begin
                trig_q <= '0;
            end

            // Inter-byte timeout, restarted by every received byte.
            if (state_q == ST_IDLE || state_q == ST_ACK || rx_valid) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                tmo_q   <= '0;
                state_q <= ST_IDLE;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_SET) begin
                            state_q <= ST_S_ZERO;
                        end else if (rx_data == CMD_TRIG) begin
                            state_q <= ST_T_ZERO;
                        end
                    end
                end
                ST_S_ZERO: begin
                    if (rx_valid) begin
                        state_q <= (rx_data == CMD_PAD) ? ST_S_CH : ST_IDLE;
                    end
                end
                ST_S_CH: begin
                    if (rx_valid) begin
                        ch_q    <= rx_data;
                        state_q <= ST_S_VAL;
                    end
                end
                ST_S_VAL: begin
                    if (rx_valid) begin
                        // An out-of-range channel still consumes the value
                        // byte, then is dropped silently.
                        if (ch_q < 8'd4) begin
                            vctr_q[ch_q[1:0]]  <= rx_data;
                            armed_q[ch_q[1:0]] <= 1'b1;
                            ack_q              <= 1'b1;
                            state_q            <= ST_ACK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_T_ZERO: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_PAD) begin
                            trig_q  <= armed_q;
                            pcnt_q  <= PW'(TRIG_W - 1);
                            armed_q <= '0;
                            ack_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign trigout_ch0 = trig_q[0];
    assign trigout_ch1 = trig_q[1];
    assign trigout_ch2 = trig_q[2];
    assign trigout_ch3 = trig_q[3];
    assign vctrout_ch0 = vctr_q[0];

endmodule

// File: tb/tb_uart_trig_ctrl.sv
module tb_uart_trig_ctrl;

    localparam int BIT = 16;
    localparam int NV  = 16;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1;
    logic       tx, txD;
    logic       t0, t1, t2, t3;
    logic [7:0] vctr0;
    logic [3:0] trig;

    assign trig = {t3, t2, t1, t0};

    always #5 clk = ~clk;

    uart_trig_ctrl #(
        .CLK_HZ       (160000),
        .BAUD         (10000),
        .TRIG_W       (12),
        .TIMEOUT_BITS (64)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx          (rx),
        .tx          (tx),
        .txD         (txD),
        .trigout_ch0 (t0),
        .trigout_ch1 (t1),
        .trigout_ch2 (t2),
        .trigout_ch3 (t3),
        .vctrout_ch0 (vctr0)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // Pulse monitor: counts completed pulses and their widths per channel.
    int run[4];
    int pcount[4];
    int pwidth[4];
    int rise[4];
    int cyc = 0;

    initial for (int c = 0; c < 4; c++) begin
        run[c] = 0; pcount[c] = 0; pwidth[c] = 0; rise[c] = 0;
    end

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (trig[c]) begin
                if (run[c] == 0) rise[c] = cyc;
                run[c]++;
            end else if (run[c] != 0) begin
                pcount[c]++;
                pwidth[c] = run[c];
                run[c] = 0;
            end
        end
        cyc++;
    end

    // TX monitor: decodes 8N1 frames on tx.
    int         ack_cnt = 0;
    logic [7:0] last_ack = 8'h00;
    logic       last_stop = 1'b0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (nrst && tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                last_stop = tx;
                last_ack  = b;
                ack_cnt++;
            end
        end
    end

    // Stimulus helpers; all drive on the falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_val;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    typedef struct {
        string           name;
        int              n;
        logic [3:0][7:0] b;
        int              gap_at;
        int              gap_bits;
        logic [3:0]      bad_stop;
        int              exp_acks;
        logic [3:0]      exp_pulse;
        logic [7:0]      exp_v0;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input int gat, input int gbits, input logic [3:0] bad,
                                input int acks, input logic [3:0] pm, input logic [7:0] v0);
        vec_t r;
        r.name = nm; r.n = n;
        r.b[0] = b0; r.b[1] = b1; r.b[2] = b2; r.b[3] = b3;
        r.gap_at = gat; r.gap_bits = gbits; r.bad_stop = bad;
        r.exp_acks = acks; r.exp_pulse = pm; r.exp_v0 = v0;
        return r;
    endfunction

    vec_t vecs[NV];
    int   a0;
    int   p0[4];

    initial begin
        vecs[0]  = mk("set_ch1_gap10",  4, 8'h53, 8'h00, 8'h01, 8'h03,  1,  10, 4'b0000, 1, 4'b0000, 8'h00);
        vecs[1]  = mk("fire_ch1",       2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0010, 8'h00);
        vecs[2]  = mk("set_ch0_00",     4, 8'h53, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0000, 8'h00);
        vecs[3]  = mk("fire_ch0",       2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0001, 8'h00);
        vecs[4]  = mk("set_ch2_15",     4, 8'h53, 8'h00, 8'h02, 8'h15, -1,   0, 4'b0000, 1, 4'b0000, 8'h00);
        vecs[5]  = mk("fire_ch2",       2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0100, 8'h00);
        vecs[6]  = mk("set_ch0_7f",     4, 8'h53, 8'h00, 8'h00, 8'h7F, -1,   0, 4'b0000, 1, 4'b0000, 8'h7F);
        vecs[7]  = mk("bad_pad",        2, 8'h53, 8'h01, 8'h00, 8'h00, -1,   0, 4'b0000, 0, 4'b0000, 8'h7F);
        vecs[8]  = mk("bad_channel",    4, 8'h53, 8'h00, 8'h05, 8'hAA, -1,   0, 4'b0000, 0, 4'b0000, 8'h7F);
        vecs[9]  = mk("timeout_gap100", 4, 8'h53, 8'h00, 8'h01, 8'h03,  1, 100, 4'b0000, 0, 4'b0000, 8'h7F);
        vecs[10] = mk("fire_ch0_again", 2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0001, 8'h7F);
        vecs[11] = mk("fire_unarmed",   2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b0000, 8'h7F);
        vecs[12] = mk("bad_stop",       4, 8'h53, 8'h00, 8'h00, 8'h44,  0,   2, 4'b0001, 0, 4'b0000, 8'h7F);
        vecs[13] = mk("set_ch1_22",     4, 8'h53, 8'h00, 8'h01, 8'h22, -1,   0, 4'b0000, 1, 4'b0000, 8'h7F);
        vecs[14] = mk("set_ch3_33",     4, 8'h53, 8'h00, 8'h03, 8'h33, -1,   0, 4'b0000, 1, 4'b0000, 8'h7F);
        vecs[15] = mk("fire_ch1_ch3",   2, 8'h5C, 8'h00, 8'h00, 8'h00, -1,   0, 4'b0000, 1, 4'b1010, 8'h7F);

        // Reset state, checked while held and after release.
        repeat (5) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_trig", int'(trig), 0);
        check("rst_vctr0", int'(vctr0), 0);
        check("rst_txD", int'(txD), 1);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_tx", int'(tx), 1);
        check("post_rst_vctr0", int'(vctr0), 0);
        // txD loopback: short low glitch, too short to be a start bit.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("txD_low", int'(txD), 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("txD_high", int'(txD), 1);
        idle_bits(4);
        $display("reset: tx=%0d trig=%b vctr0=%02h txD=%0d", tx, trig, vctr0, txD);

        for (int v = 0; v < NV; v++) begin
            a0 = ack_cnt;
            for (int c = 0; c < 4; c++) p0[c] = pcount[c];
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].b[i], ~vecs[v].bad_stop[i]);
                if (i == vecs[v].gap_at) idle_bits(vecs[v].gap_bits);
            end
            idle_bits(14);
            check({vecs[v].name, "_acks"}, ack_cnt - a0, vecs[v].exp_acks);
            if (vecs[v].exp_acks > 0) begin
                check({vecs[v].name, "_ackbyte"}, int'(last_ack), 8'hA5);
                check({vecs[v].name, "_ackstop"}, int'(last_stop), 1);
            end
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_pulses_ch%0d", vecs[v].name, c),
                      pcount[c] - p0[c], int'(vecs[v].exp_pulse[c]));
                if (vecs[v].exp_pulse[c] && pcount[c] != p0[c])
                    check($sformatf("%s_width_ch%0d", vecs[v].name, c), pwidth[c], 12);
            end
            check({vecs[v].name, "_vctr0"}, int'(vctr0), int'(vecs[v].exp_v0));
            $display("vec %0d %s: acks=%0d pulses=%0d%0d%0d%0d vctr0=%02h",
                     v, vecs[v].name, ack_cnt - a0, pcount[3] - p0[3], pcount[2] - p0[2],
                     pcount[1] - p0[1], pcount[0] - p0[0], vctr0);
        end
        // ch1 and ch3 fired by the same command must rise together.
        check("same_cycle_rise", rise[3], rise[1]);

        // Reset in the middle of a set command's value byte.
        send_byte(8'h53, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1);
        idle_bits(14);
        send_byte(8'h53, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        nrst = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_tx", int'(tx), 1);
        check("midrst_trig", int'(trig), 0);
        check("midrst_vctr0", int'(vctr0), 0);
        check("midrst_txD", int'(txD), 1);
        nrst = 1'b1;
        idle_bits(14);
        a0 = ack_cnt;
        for (int c = 0; c < 4; c++) p0[c] = pcount[c];
        send_byte(8'h5C, 1'b1); send_byte(8'h00, 1'b1);
        idle_bits(14);
        check("midrst_fire_acks", ack_cnt - a0, 1);
        check("midrst_fire_ackbyte", int'(last_ack), 8'hA5);
        for (int c = 0; c < 4; c++)
            check($sformatf("midrst_fire_pulses_ch%0d", c), pcount[c] - p0[c], 0);
        check("midrst_fire_vctr0", int'(vctr0), 0);
        $display("reset mid-command then fire: acks=%0d vctr0=%02h", ack_cnt - a0, vctr0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
